pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/pipe_hazard_ctrl_if.sv | 28 ++
 rtl/hazard_cmp.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 64 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared register-index width and hazard controller state encoding.
package pipe_ctrl_pkg;
  localparam int REG_IDX_W = 3;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] ABORT    = 2'd3;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side stage contents and controller enables/clears.
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; #(parameter int CNT_W = 16);
  reg_idx_t id_rm, id_rn, id_sm, id_sn, ex_rd, ex_sd, mem_rd, mem_sd;
  logic id_use_rm, id_use_rn, id_use_sm, id_use_sn;
  logic ex_r_regwrite, ex_s_regwrite, ex_memread;
  logic mem_r_regwrite, mem_s_regwrite, mem_access, mem_branch_taken, dmem_ack;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble;
  logic dmem_req, mem_timeout;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rm, id_rn, id_sm, id_sn, id_use_rm, id_use_rn, id_use_sm, id_use_sn,
    output ex_rd, ex_sd, ex_r_regwrite, ex_s_regwrite, ex_memread,
    output mem_rd, mem_sd, mem_r_regwrite, mem_s_regwrite, mem_access, mem_branch_taken, dmem_ack,
    input pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble,
    input dmem_req, mem_timeout, state, stall_cnt
  );
  modport slave (
    input id_rm, id_rn, id_sm, id_sn, id_use_rm, id_use_rn, id_use_sm, id_use_sn,
    input ex_rd, ex_sd, ex_r_regwrite, ex_s_regwrite, ex_memread,
    input mem_rd, mem_sd, mem_r_regwrite, mem_s_regwrite, mem_access, mem_branch_taken, dmem_ack,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble,
    output dmem_req, mem_timeout, state, stall_cnt
  );
endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp: RAW match of two ID sources against the EX and MEM destinations of one register file.
module hazard_cmp import pipe_ctrl_pkg::*; (
  input  reg_idx_t a,
  input  reg_idx_t b,
  input  logic     use_a,
  input  logic     use_b,
  input  reg_idx_t ex_rd,
  input  logic     ex_we,
  input  reg_idx_t mem_rd,
  input  logic     mem_we,
  output logic     ex_hit,
  output logic     mem_hit
);
  assign ex_hit  = ex_we & ((use_a & (a == ex_rd)) | (use_b & (b == ex_rd)));
  assign mem_hit = mem_we & ((use_a & (a == mem_rd)) | (use_b & (b == mem_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / memory-wait / branch-flush control for a 5-stage pipeline.
// PIPE_HAZARD_FWD_EN defined: forwarding exists, only EX loads stall; else any EX/MEM RAW stalls.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0] st, nxt;
  logic [TW-1:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic r_ex, r_mem, s_ex, s_mem, hit, aborted, waiting, mstall, br, lu, go, timeout_hit;
  hazard_cmp u_r (
    .a(bus.id_rm), .b(bus.id_rn), .use_a(bus.id_use_rm), .use_b(bus.id_use_rn),
    .ex_rd(bus.ex_rd), .ex_we(bus.ex_r_regwrite), .mem_rd(bus.mem_rd), .mem_we(bus.mem_r_regwrite),
    .ex_hit(r_ex), .mem_hit(r_mem)
  );
  hazard_cmp u_s (
    .a(bus.id_sm), .b(bus.id_sn), .use_a(bus.id_use_sm), .use_b(bus.id_use_sn),
    .ex_rd(bus.ex_sd), .ex_we(bus.ex_s_regwrite), .mem_rd(bus.mem_sd), .mem_we(bus.mem_s_regwrite),
    .ex_hit(s_ex), .mem_hit(s_mem)
  );
`ifdef PIPE_HAZARD_FWD_EN
  assign hit = (r_ex | s_ex) & bus.ex_memread & (st == RUN);
`else
  assign hit = r_ex | s_ex | r_mem | s_mem;
`endif
  assign aborted = st == ABORT;
  assign waiting = st == MEM_WAIT;
  // once waiting, the request is held regardless of mem_access until ack
  assign mstall = !aborted & (waiting | bus.mem_access) & !bus.dmem_ack;
  assign br = !aborted & !mstall & bus.mem_branch_taken;
  assign lu = !aborted & !mstall & !br & hit;
  assign go = !reset & !aborted & !mstall;
  assign timeout_hit = waiting & mstall & (wcnt == TW'(MEM_TIMEOUT - 1));
  assign bus.pc_we = go & !lu;
  assign bus.if_id_we = go & !lu;
  assign bus.id_ex_we = go;
  assign bus.ex_mem_we = go;
  assign bus.mem_wb_we = !reset & !aborted;
  assign bus.if_id_flush = reset | br;
  assign bus.id_ex_bubble = reset | br | lu;
  assign bus.ex_mem_flush = reset | br;
  assign bus.mem_wb_bubble = reset | mstall;
  assign bus.dmem_req = !reset & !aborted & (waiting | bus.mem_access);
  assign bus.mem_timeout = !reset & aborted;
  assign bus.state = st;
  assign bus.stall_cnt = cnt;
  always_comb nxt = (aborted | timeout_hit) ? ABORT : mstall ? MEM_WAIT : lu ? LU_STALL : RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RUN;
      wcnt <= '0;
      cnt <= '0;
    end else begin
      st <= nxt;
      wcnt <= (waiting & mstall) ? wcnt + 1'b1 : '0;
      if (!bus.pc_we && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios then random traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0;
  int mst, mwait, mcnt, m_nst;
  logic [10:0] e_ctl;
  int n_req, n_stall;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(16)) b ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (.clk(clk), .reset(rst), .bus(b));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {b.id_rm, b.id_rn, b.id_sm, b.id_sn, b.ex_rd, b.ex_sd, b.mem_rd, b.mem_sd} = '0;
    {b.id_use_rm, b.id_use_rn, b.id_use_sm, b.id_use_sn} = '0;
    {b.ex_r_regwrite, b.ex_s_regwrite, b.ex_memread} = '0;
    {b.mem_r_regwrite, b.mem_s_regwrite, b.mem_access, b.mem_branch_taken, b.dmem_ack} = '0;
  endtask

  // Expected outputs for this cycle from the hazard rules and priorities.
  task automatic model_eval();
    logic [2:0] src[4];
    bit usev[4];
    bit he, hm, stall, lu, req;
    src = '{b.id_rm, b.id_rn, b.id_sm, b.id_sn};
    usev = '{b.id_use_rm, b.id_use_rn, b.id_use_sm, b.id_use_sn};
    he = 0;
    hm = 0;
    for (int i = 0; i < 4; i++) begin
      if (usev[i] && (i < 2 ? (b.ex_r_regwrite && src[i] == b.ex_rd) : (b.ex_s_regwrite && src[i] == b.ex_sd))) he = 1;
      if (usev[i] && (i < 2 ? (b.mem_r_regwrite && src[i] == b.mem_rd) : (b.mem_s_regwrite && src[i] == b.mem_sd))) hm = 1;
    end
`ifdef PIPE_HAZARD_FWD_EN
    lu = he && b.ex_memread && mst == 0;
`else
    lu = he || hm;
`endif
    req = mst == 2 || b.mem_access;
    stall = req && !b.dmem_ack;
    if (rst) begin
      e_ctl = 11'b00000_1111_0_0;
      m_nst = 0;
    end else if (mst == 3) begin
      e_ctl = 11'b00000_0000_0_1;
      m_nst = 3;
    end else if (stall) begin
      e_ctl = {5'b00001, 4'b0001, 1'b1, 1'b0};
      m_nst = (mst == 2 && mwait + 1 >= TO) ? 3 : 2;
    end else if (b.mem_branch_taken) begin
      e_ctl = {5'b11111, 4'b1110, req, 1'b0};
      m_nst = 0;
    end else if (lu) begin
      e_ctl = {5'b00111, 4'b0100, req, 1'b0};
      m_nst = 1;
    end else begin
      e_ctl = {5'b11111, 4'b0000, req, 1'b0};
      m_nst = 0;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      mst = 0;
      mwait = 0;
      mcnt = 0;
    end else begin
      if (!e_ctl[10] && mcnt < 65535) mcnt++;
      mwait = (mst == 2 && m_nst == 2) ? mwait + 1 : 0;
      mst = m_nst;
    end
  endtask

  task automatic tick(string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".ctl"}, 32'({b.pc_we, b.if_id_we, b.id_ex_we, b.ex_mem_we, b.mem_wb_we, b.if_id_flush,
        b.id_ex_bubble, b.ex_mem_flush, b.mem_wb_bubble, b.dmem_req, b.mem_timeout}), 32'(e_ctl));
    chk({tag, ".state"}, 32'(b.state), 32'(mst));
    chk({tag, ".cnt"}, 32'(b.stall_cnt), 32'(mcnt));
    n_req += int'(b.dmem_req);
    n_stall += int'(!b.pc_we);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
    n_req = 0;
    n_stall = 0;
  endtask

  initial begin
    mst = 0;
    mwait = 0;
    mcnt = 0;
    n_req = 0;
    n_stall = 0;
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    // load-use on R file: one stall cycle, then the load has moved on
    b.id_rm = 3; b.id_use_rm = 1; b.ex_rd = 3; b.ex_r_regwrite = 1; b.ex_memread = 1;
    tick("lu0");
    chk("lu.state", 32'(b.state), 32'd1);
    clr();
    tick("lu1");
    chk("lu.back", 32'(b.state), 32'd0);
    chk("lu.stalls", 32'(n_stall), 32'd1);
    // memory wait, ack arrives on the fifth requesting cycle
    do_reset();
    b.mem_access = 1;
    repeat (4) tick("mw");
    b.dmem_ack = 1;
    tick("mw.ack");
    clr();
    tick("mw.after");
    chk("mw.req", 32'(n_req), 32'd5);
    chk("mw.stall", 32'(n_stall), 32'd4);
    chk("mw.cnt", 32'(b.stall_cnt), 32'd4);
    // branch overrides a concurrent load-use
    do_reset();
    b.mem_branch_taken = 1; b.id_sm = 6; b.id_use_sm = 1; b.ex_sd = 6; b.ex_s_regwrite = 1; b.ex_memread = 1;
    tick("br");
    chk("br.state", 32'(b.state), 32'd0);
    chk("br.stall", 32'(n_stall), 32'd0);
    clr();
    tick("br.after");
    // no forwarding: MEM-stage S match stalls while it holds
    do_reset();
    b.mem_sd = 5; b.mem_s_regwrite = 1; b.id_sn = 5; b.id_use_sn = 1;
    repeat (3) tick("nofwd");
`ifndef PIPE_HAZARD_FWD_EN
    chk("nofwd.stall", 32'(n_stall), 32'd3);
`endif
    clr();
    tick("nofwd.clear");
    // timeout into ABORT, held until reset
    do_reset();
    b.mem_access = 1;
    repeat (TO + 1) tick("to");
    chk("to.state", 32'(b.state), 32'd3);
    b.mem_access = 0;
    b.dmem_ack = 1;
    repeat (3) tick("abort");
    chk("abort.to", 32'(b.mem_timeout), 32'd1);
    chk("abort.req", 32'(b.dmem_req), 32'd0);
    chk("abort.state", 32'(b.state), 32'd3);
    // reset while waiting
    do_reset();
    b.mem_access = 1;
    repeat (2) tick("rw");
    chk("rw.wait", 32'(b.state), 32'd2);
    rst = 1'b1;
    tick("rw.rst");
    rst = 1'b0;
    b.mem_access = 0;
    chk("rw.state", 32'(b.state), 32'd0);
    chk("rw.cnt", 32'(b.stall_cnt), 32'd0);
    chk("rw.req", 32'(b.dmem_req), 32'd0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      {b.id_rm, b.id_rn, b.id_sm, b.id_sn} = 12'($urandom);
      {b.ex_rd, b.ex_sd, b.mem_rd, b.mem_sd} = 12'($urandom);
      {b.id_use_rm, b.id_use_rn, b.id_use_sm, b.id_use_sn} = 4'($urandom);
      {b.ex_r_regwrite, b.ex_s_regwrite, b.ex_memread, b.mem_r_regwrite, b.mem_s_regwrite} = 5'($urandom);
      b.mem_access = $urandom_range(0, 3) == 0;
      b.dmem_ack = $urandom_range(0, 2) == 0;
      b.mem_branch_taken = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 59) == 0;
      tick("rand");
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
